// File: rtl/relax_priority_queue.sv
// Tentative-distance table for Dijkstra: guarded relax writes, path readback and a
// multi-lane sequential min-extraction over the unvisited, reachable nodes.
module relax_priority_queue #(
  parameter int MAX_NODES   = 64,
  parameter int INDEX_WIDTH = 6,
  parameter int VALUE_WIDTH = 16,
  parameter int LANES       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   init_en,
  input  logic [INDEX_WIDTH-1:0] source_index,
  input  logic                   relax_en,
  output logic                   relax_ready,
  input  logic [INDEX_WIDTH-1:0] relax_index,
  input  logic [VALUE_WIDTH-1:0] relax_value,
  input  logic [INDEX_WIDTH-1:0] relax_pred,
  output logic                   relax_updated,
  input  logic [INDEX_WIDTH-1:0] read_index,
  output logic [VALUE_WIDTH-1:0] read_value,
  output logic [INDEX_WIDTH-1:0] read_pred,
  input  logic                   extract_req,
  output logic                   extract_busy,
  output logic                   extract_valid,
  output logic                   extract_empty,
  output logic [INDEX_WIDTH-1:0] extract_index,
  output logic [VALUE_WIDTH-1:0] extract_value,
  output logic [INDEX_WIDTH:0]   visited_count
);
  localparam int NUM_CHUNKS  = MAX_NODES / LANES;
  localparam int CHUNK_WIDTH = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int ADDR_W      = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam logic [VALUE_WIDTH-1:0] INFINITY = '1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [VALUE_WIDTH-1:0] r_dist [MAX_NODES];
  logic [INDEX_WIDTH-1:0] r_pred [MAX_NODES];
  logic [MAX_NODES-1:0]   r_visited;
  logic [CHUNK_WIDTH-1:0] r_chunk;
  logic                   r_best_found;
  logic [VALUE_WIDTH-1:0] r_best_value;
  logic [INDEX_WIDTH-1:0] r_best_index;
  logic                   r_relax_updated;
  logic                   r_extract_empty;
  logic [INDEX_WIDTH-1:0] r_extract_index;
  logic [VALUE_WIDTH-1:0] r_extract_value;
  logic [INDEX_WIDTH:0]   r_visited_count;

  logic                   w_relax_in_range, w_read_in_range, w_relax_write, w_last_chunk;
  logic [ADDR_W-1:0]      w_relax_addr, w_read_addr;
  logic [LANES-1:0]       w_lane_cand;
  logic [VALUE_WIDTH-1:0] w_lane_value [LANES];
  logic [INDEX_WIDTH-1:0] w_lane_index [LANES];
  logic                   w_red_found, w_merge_found;
  logic [VALUE_WIDTH-1:0] w_red_value, w_merge_value;
  logic [INDEX_WIDTH-1:0] w_red_index, w_merge_index;

  assign extract_busy  = (r_state != S_IDLE);
  assign extract_valid = (r_state == S_DONE);
  assign relax_ready   = !extract_busy;
  assign relax_updated = r_relax_updated;
  assign extract_empty = r_extract_empty;
  assign extract_index = r_extract_index;
  assign extract_value = r_extract_value;
  assign visited_count = r_visited_count;

  assign w_relax_in_range = ({1'b0, relax_index} < (INDEX_WIDTH+1)'(MAX_NODES));
  assign w_read_in_range  = ({1'b0, read_index} < (INDEX_WIDTH+1)'(MAX_NODES));
  assign w_relax_addr     = relax_index[ADDR_W-1:0];
  assign w_read_addr      = read_index[ADDR_W-1:0];
  assign read_value       = w_read_in_range ? r_dist[w_read_addr] : INFINITY;
  assign read_pred        = w_read_in_range ? r_pred[w_read_addr] : '0;
  assign w_last_chunk     = (r_chunk == CHUNK_WIDTH'(NUM_CHUNKS - 1));

  // Init has priority, and a relax against a visited node is dropped silently.
  assign w_relax_write = relax_en && relax_ready && !init_en && w_relax_in_range &&
                         !r_visited[w_relax_addr] && (relax_value < r_dist[w_relax_addr]);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ADDR_W-1:0] w_addr;
    assign w_addr           = ADDR_W'(int'(r_chunk) * LANES + gi);
    assign w_lane_index[gi] = INDEX_WIDTH'(w_addr);
    assign w_lane_value[gi] = r_dist[w_addr];
    assign w_lane_cand[gi]  = !r_visited[w_addr] && (r_dist[w_addr] != INFINITY);
  end

  // Ascending lane order with strict compare keeps the lower index on ties; chunk
  // indices always exceed best's, so best also wins ties on the merge.
  always_comb begin
    w_red_found = 1'b0;
    w_red_value = INFINITY;
    w_red_index = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_lane_cand[l] && (!w_red_found || (w_lane_value[l] < w_red_value))) begin
        w_red_found = 1'b1;
        w_red_value = w_lane_value[l];
        w_red_index = w_lane_index[l];
      end
    end
    w_merge_found = r_best_found;
    w_merge_value = r_best_value;
    w_merge_index = r_best_index;
    if (w_red_found && (!r_best_found || (w_red_value < r_best_value))) begin
      w_merge_found = 1'b1;
      w_merge_value = w_red_value;
      w_merge_index = w_red_index;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (extract_req) w_state_next = S_SCAN;
      S_SCAN:  if (w_last_chunk) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (init_en) w_state_next = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        r_dist[i] <= INFINITY;
        r_pred[i] <= '0;
      end
      r_visited       <= '0;
      r_state         <= S_IDLE;
      r_chunk         <= '0;
      r_best_found    <= 1'b0;
      r_best_value    <= INFINITY;
      r_best_index    <= '0;
      r_relax_updated <= 1'b0;
      r_extract_empty <= 1'b0;
      r_extract_index <= '0;
      r_extract_value <= INFINITY;
      r_visited_count <= '0;
    end else begin
      r_state         <= w_state_next;
      r_relax_updated <= w_relax_write;
      if (init_en) begin
        for (int i = 0; i < MAX_NODES; i++) begin
          r_dist[i] <= (i == int'(source_index)) ? '0 : INFINITY;
          r_pred[i] <= source_index;
        end
        r_visited       <= '0;
        r_visited_count <= '0;
      end else begin
        if (w_relax_write) begin
          r_dist[w_relax_addr] <= relax_value;
          r_pred[w_relax_addr] <= relax_pred;
        end
        if (r_state == S_IDLE && extract_req) begin
          r_chunk      <= '0;
          r_best_found <= 1'b0;
          r_best_value <= INFINITY;
          r_best_index <= '0;
        end
        // The result is registered on entry to DONE so it is visible with extract_valid.
        if (r_state == S_SCAN) begin
          r_chunk      <= r_chunk + CHUNK_WIDTH'(1);
          r_best_found <= w_merge_found;
          r_best_value <= w_merge_value;
          r_best_index <= w_merge_index;
          if (w_last_chunk) begin
            r_extract_empty <= !w_merge_found;
            r_extract_index <= w_merge_found ? w_merge_index : '0;
            r_extract_value <= w_merge_found ? w_merge_value : INFINITY;
            if (w_merge_found) begin
              r_visited[w_merge_index[ADDR_W-1:0]] <= 1'b1;
              r_visited_count <= r_visited_count + (INDEX_WIDTH+1)'(1);
            end
          end
        end
      end
    end
  end
endmodule

// File: doc/relax_priority_queue.md
Name: relax_priority_queue

Overview:
- Parametrised successor to the Dijkstra distance store.
- Holds tentative distance, predecessor and visited bit per node, and applies guarded relax writes that only take a strictly smaller distance.
- Extracts the minimum unvisited node with a multi-lane sequential scan, using a req/valid handshake.
- Sits between the edge-expansion FSM, which issues relaxes, and the Dijkstra controller, which issues init/extract and reads back the path.

Parameters:
- MAX_NODES, 64, number of nodes. Must be a multiple of LANES.
- INDEX_WIDTH, 6, node index width. 2^INDEX_WIDTH >= MAX_NODES.
- VALUE_WIDTH, 16, distance width. INFINITY = all ones.
- LANES, 4, entries compared per scan cycle. Power of two, 1..MAX_NODES.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- init_en  in  1  start new search: clear table, seed source
- source_index  in  INDEX_WIDTH  source node, sampled with init_en
- relax_en  in  1  relax request
- relax_ready  out  1  high when a relax is accepted this cycle (= !extract_busy)
- relax_index  in  INDEX_WIDTH  target node
- relax_value  in  VALUE_WIDTH  candidate distance
- relax_pred  in  INDEX_WIDTH  candidate predecessor
- relax_updated  out  1  registered pulse: previous accepted relax wrote the table
- read_index  in  INDEX_WIDTH  random-read address
- read_value  out  VALUE_WIDTH  dist[read_index], combinational
- read_pred  out  INDEX_WIDTH  pred[read_index], combinational
- extract_req  in  1  request minimum extraction
- extract_busy  out  1  scan in progress
- extract_valid  out  1  one-cycle result pulse
- extract_empty  out  1  qualifies extract_valid: no reachable unvisited node
- extract_index  out  INDEX_WIDTH  min node
- extract_value  out  VALUE_WIDTH  min distance
- visited_count  out  INDEX_WIDTH+1  number of visited nodes

Behaviour:
- Reset:
  - dist = INFINITY, pred = 0, visited = 0, state IDLE.
  - All registered outputs 0, except extract_value = INFINITY.
  - Reset mid-scan aborts the scan; no extract_valid is produced.
- Init (init_en=1), 1 cycle:
  - dist = INFINITY for all nodes, except dist[source_index] = 0.
  - pred[all] = source_index; visited = 0; visited_count = 0.
  - Priority: init beats relax and extract in the same cycle.
  - Init during SCAN aborts the scan; no valid.
- Relax:
  - Accepted only when relax_en && relax_ready.
  - Writes dist and pred iff !visited[relax_index] && relax_value < dist[relax_index] (strict, unsigned).
  - relax_updated is 1 in the next cycle iff the write happened.
  - Equal value, a visited target, or relax_index >= MAX_NODES: no write, relax_updated = 0.
  - While busy, the caller holds the request; it is not queued.
- read_value/read_pred reflect writes from the cycle after the write edge. No bypass.
- FSM IDLE -> SCAN -> DONE -> IDLE:
  - IDLE: extract_req=1 (and no init) -> SCAN. Clear best = {INFINITY, idx 0, found=0} and chunk = 0.
  - SCAN: each cycle examines entries chunk*LANES .. chunk*LANES+LANES-1.
    - Candidate iff !visited && dist != INFINITY.
    - Reduce by smallest dist; ties go to the lower index. Merge with best using the same rule; best holds on tie.
    - chunk++. After chunk MAX_NODES/LANES-1 -> DONE.
  - DONE, 1 cycle:
    - extract_valid = 1.
    - If found: extract_index/value = best, set visited[best], visited_count++, extract_empty = 0.
    - If not found: extract_empty = 1, extract_index = 0, extract_value = INFINITY.
    - -> IDLE.
  - extract_busy = 1 in SCAN and DONE.
  - Latency: req at cycle t -> valid at t + MAX_NODES/LANES + 1.
- extract_req while busy is ignored; it is not queued.
- extract_index/value/empty hold between valid pulses.
- Table is frozen during SCAN (relax_ready = 0), so the scan result is coherent.

Test Plan:
- MAX_NODES=8, LANES=2. Reset, then init source=3; read_index=3 -> read_value=0, read_pred=3; read_index=5 -> 0xFFFF, read_pred=3.
- Relax(5,10,p3) -> relax_updated=1, dist[5]=10, pred[5]=3. Then relax(5,10) and relax(5,12) -> relax_updated=0, dist stays 10. Then relax(5,7,p1) -> dist=7, pred=1.
- Extract after init -> valid exactly 5 cycles after req, index 3, value 0, visited_count=1. Relax(3,0) afterwards -> no update (visited).
- dist[2]=dist[6]=4 (others INF/visited) -> extract gives index 2. The next extract gives 6. The next gives extract_empty=1, value 0xFFFF, index 0.
- Relax asserted during SCAN -> relax_ready=0, no write. Held relax completes the cycle after DONE. A second extract_req during the scan yields only one valid.
- Init, and separately reset, asserted mid-SCAN -> no extract_valid. Table reinitialised (init) or cleared (reset); next extract behaves normally.
